// File: rtl/mips_ctrl_pkg.sv
// Shared control-unit definitions: state width and microstore next-address codes.
// Used by the control sequencer and the instruction encoder.
package mips_ctrl_pkg;

  localparam int STATE_W = 7;

  typedef logic [STATE_W-1:0] state_t;

  // Codes 6 and 7 are reserved and behave like NXT_FETCH.
  typedef enum logic [2:0] {
    NXT_INC      = 3'd0,
    NXT_JUMP     = 3'd1,
    NXT_DECODE   = 3'd2,
    NXT_COND     = 3'd3,
    NXT_WAIT_MOC = 3'd4,
    NXT_FETCH    = 3'd5
  } nxt_type_e;

  function automatic state_t state_inc(input state_t s);
    return s + state_t'(1);
  endfunction

endpackage

// File: rtl/moc_watchdog.sv
// Counts consecutive cycles a wait state holds for MOC and flags the last allowed one.
// Only instantiated in builds with MOC_TIMEOUT_EN defined.
module moc_watchdog #(
  parameter int MOC_TIMEOUT = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Hold,
  input  logic Clear,
  output logic Expired
);

  localparam int CNT_W = (MOC_TIMEOUT > 2) ? $clog2(MOC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  // Expiry forces a state change, so the count restarts alongside Clear.
  assign Expired = Hold && (count_q == LAST);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else if (Clear || Expired) begin
      count_q <= '0;
    end else if (Hold) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Microsequencer for the multicycle MIPS control unit: registers the control state and picks the next.
// Optional memory-timeout watchdog enabled by defining MOC_TIMEOUT_EN.
module control_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [STATE_W-1:0] RESET_STATE   = 7'd0,
  parameter logic [STATE_W-1:0] FETCH_STATE   = 7'd1,
  parameter logic [STATE_W-1:0] ILLEGAL_STATE = 7'd0,
  parameter logic [STATE_W-1:0] ERROR_STATE   = 7'd127,
  parameter int                 MOC_TIMEOUT   = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [STATE_W-1:0] State_Sel,
  input  logic [2:0]         Nxt_Type,
  input  logic [STATE_W-1:0] Nxt_Target,
  input  logic               Cond,
  input  logic               MOC,
  input  logic               Stall,
  output logic [STATE_W-1:0] State,
  output logic               Moc_Wait,
  output logic               Illegal_Instr,
  output logic               Bus_Err
);

  if (MOC_TIMEOUT < 2) begin : g_bad_moc_timeout
    $error("control_sequencer: MOC_TIMEOUT must be at least 2");
  end

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   bus_err_q, bus_err_d;
  logic   wait_hold;
  logic   expired;

  // Memory handshake: MOC is sampled level-wise every cycle a NXT_WAIT_MOC word is
  // current; the sequencer advances on the edge where MOC=1 and keeps no request state.
  assign Moc_Wait  = (Nxt_Type == NXT_WAIT_MOC) && !MOC;
  assign wait_hold = !Stall && Moc_Wait;

`ifdef MOC_TIMEOUT_EN
  moc_watchdog #(
    .MOC_TIMEOUT(MOC_TIMEOUT)
  ) u_moc_watchdog (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .Hold   (wait_hold),
    .Clear  (!Stall && !wait_hold),
    .Expired(expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    if (!Stall) begin
      case (Nxt_Type)
        NXT_INC:    state_d = state_inc(state_q);
        NXT_JUMP:   state_d = Nxt_Target;
        NXT_DECODE: begin
          if (State_Sel == '0) begin
            state_d   = ILLEGAL_STATE;
            illegal_d = 1'b1;
          end else begin
            state_d = State_Sel;
          end
        end
        NXT_COND:   state_d = Cond ? Nxt_Target : state_inc(state_q);
        NXT_WAIT_MOC: begin
          if (MOC) begin
            state_d = state_inc(state_q);
          end else if (expired) begin
            state_d   = ERROR_STATE;
            bus_err_d = 1'b1;
          end
        end
        NXT_FETCH:  state_d = FETCH_STATE;
        default:    state_d = FETCH_STATE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign State         = state_q;
  assign Illegal_Instr = illegal_q;
  assign Bus_Err       = bus_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed scenarios plus randomized microstore words.
// Honors MOC_TIMEOUT_EN in its reference model when the build defines it.
module tb_control_sequencer;

  localparam int TIMEOUT = 16;
`ifdef MOC_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [6:0] State_Sel = '0;
  logic [2:0] Nxt_Type = '0;
  logic [6:0] Nxt_Target = '0;
  logic       Cond = 1'b0;
  logic       MOC = 1'b0;
  logic       Stall = 1'b0;
  logic [6:0] State;
  logic       Moc_Wait;
  logic       Illegal_Instr;
  logic       Bus_Err;

  control_sequencer #(.MOC_TIMEOUT(TIMEOUT)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .State_Sel    (State_Sel),
    .Nxt_Type     (Nxt_Type),
    .Nxt_Target   (Nxt_Target),
    .Cond         (Cond),
    .MOC          (MOC),
    .Stall        (Stall),
    .State        (State),
    .Moc_Wait     (Moc_Wait),
    .Illegal_Instr(Illegal_Instr),
    .Bus_Err      (Bus_Err)
  );

  // Clock / reset
  always #5 Clk = ~Clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  int         m_state = 0;
  int         m_wait_cycles = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Driver: one microstore word per cycle; the model predicts the state after the next edge.
  task automatic step(input int nt, input int tgt, input int sel, input int c,
                      input int moc, input int st);
    int nxt;
    bit ill;
    bit bus;
    @(negedge Clk);
    Reset_n    = 1'b1;
    Nxt_Type   = 3'(nt);
    Nxt_Target = 7'(tgt);
    State_Sel  = 7'(sel);
    Cond       = c[0];
    MOC        = moc[0];
    Stall      = st[0];
    nxt = m_state;
    ill = 1'b0;
    bus = 1'b0;
    if (st == 0) begin
      case (nt)
        0: nxt = (m_state + 1) % 128;
        1: nxt = tgt;
        2: if (sel == 0) begin nxt = 0; ill = 1'b1; end else nxt = sel;
        3: nxt = (c != 0) ? tgt : (m_state + 1) % 128;
        4: begin
          if (moc != 0) nxt = (m_state + 1) % 128;
          else if (WD_EN && m_wait_cycles == TIMEOUT - 1) begin nxt = 127; bus = 1'b1; end
        end
        default: nxt = 1;
      endcase
      if (nt == 4 && moc == 0 && !bus) m_wait_cycles++;
      else m_wait_cycles = 0;
    end
    m_state = nxt;
    exp_q.push_back({7'(nxt), ill, bus});
    #1;
    check("moc_wait", int'(Moc_Wait), int'(nt == 4 && moc == 0));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    m_state = 0;
    m_wait_cycles = 0;
    #1;
    check("reset_state", int'(State), 0);
    check("reset_illegal", int'(Illegal_Instr), 0);
    check("reset_bus_err", int'(Bus_Err), 0);
  endtask

  // Scoreboard monitor: compares each registered result just after its edge.
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("state", int'(State), int'(mon_e[8:2]));
      check("illegal_instr", int'(Illegal_Instr), int'(mon_e[1]));
      check("bus_err", int'(Bus_Err), int'(mon_e[0]));
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge Clk);
    #1;
    check("init_state", int'(State), 0);
    check("init_illegal", int'(Illegal_Instr), 0);
    check("init_bus_err", int'(Bus_Err), 0);

    step(1, 1, 0, 0, 0, 0);                       // release, jump to fetch
    step(1, 2, 0, 0, 0, 0);
    step(2, 0, 13, 0, 0, 0);                      // dispatch to 13
    step(1, 2, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);                       // illegal dispatch
    step(0, 0, 0, 0, 0, 0);                       // pulse must drop
    step(1, 11, 0, 0, 0, 0);
    step(3, 40, 0, 1, 0, 0);                      // branch taken
    step(1, 11, 0, 0, 0, 0);
    step(3, 40, 0, 0, 0, 0);                      // branch not taken
    step(1, 13, 0, 0, 0, 0);
    repeat (5) step(4, 0, 0, 0, 0, 0);            // memory wait
    step(4, 0, 0, 0, 1, 0);
    step(1, 50, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1);            // stalled increment
    step(0, 0, 0, 0, 0, 0);
    step(1, 127, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);                       // wrap to 0

    step(1, 20, 0, 0, 0, 0);
    repeat (TIMEOUT) step(4, 0, 0, 0, 0, 0);      // timeout, or hold without watchdog
    step(1, 20, 0, 0, 0, 0);
    repeat (TIMEOUT - 1) step(4, 0, 0, 0, 0, 0);
    step(4, 0, 0, 0, 1, 0);                       // MOC on the last cycle wins
    step(1, 30, 0, 0, 0, 0);
    repeat (4) step(4, 0, 0, 0, 0, 0);
    repeat (2) step(4, 0, 0, 0, 0, 1);            // stall freezes the wait count
    repeat (TIMEOUT - 4) step(4, 0, 0, 0, 0, 0);
    step(1, 13, 0, 0, 0, 0);
    repeat (100) step(4, 0, 0, 0, 0, 0);          // long wait

    step(1, 2, 0, 0, 0, 0);
    step(2, 0, 0, 0, 0, 0);
    do_reset();                                   // reset while the illegal pulse is high
    step(1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        n = $urandom_range(8, 20);
        for (int j = 0; j < n; j++)
          step(4, 0, 0, 0, ($urandom_range(0, 15) == 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? 1 : 0);
      end else begin
        step($urandom_range(0, 7), $urandom_range(0, 127),
             ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127),
             $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? 1 : 0,
             ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge Clk);
    #2;
    check("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
